key_expand_ctrl: RTL and testbench
==================================

# key_expand_ctrl

Sequencer for the AES key expansion. On a load request it drives the `keysched` block through rounds 1–10, chaining each new round key back as the next `last_key`. It stores all 11 round keys (round 0 = cipher key) in an internal table for the encrypt/decrypt datapath to read by index. `keysched` and its shared S-box are instantiated by the AES top level; this block only drives the `keysched` handshake.

## Interface
- `TIMEOUT`, default 8: maximum WAIT cycles allowed per round before abort. Must be ≥ 5.
- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `load_i` input 1: start an expansion of `key_i`. Accepted only in IDLE.
- `key_i` input 128: cipher key, sampled on accept.
- `busy_o` output 1: expansion in progress.
- `done_o` output 1: the table holds a complete expansion (level signal).
- `err_o` output 1: the last expansion aborted on timeout. Sticky until the next accept.
- `rk_addr_i` input 4: round-key read index.
- `rk_o` output 128: round key `rk_addr_i`, registered read.
- `ks_start_o` output 1: one-cycle start pulse to `keysched`.
- `ks_round_o` output 4: round number for `keysched` (selects rcon).
- `ks_last_key_o` output 128: previous round key for `keysched`.
- `ks_new_key_i` input 128: key result from `keysched`.
- `ks_ready_i` input 1: one-cycle result-valid pulse from `keysched`.

## Operation
- **Reset values.** All outputs are 0. State is IDLE, round counter is 0, and every table entry is 0.
- **IDLE**
  - If `load_i` is high: write `key_i` into entry 0, load `ks_last_key_o` with `key_i`, set `ks_round_o` to 1, clear `done_o` and `err_o`, and go to START.
  - `load_i` is ignored in any other state.
- **START**
  - Assert `ks_start_o` for exactly this one cycle.
  - Clear the wait counter and go to WAIT.
- **WAIT**
  - Increment the wait counter each cycle.
  - If `ks_ready_i` is high:
    - Write `ks_new_key_i` into entry `ks_round_o` and copy it into `ks_last_key_o`.
    - If the round is 10: go to IDLE and set `done_o`.
    - Otherwise: increment `ks_round_o` and go to START.
  - Else, if the counter reaches `TIMEOUT`: set `err_o`, leave `done_o` at 0, and go to IDLE. Entries already written are kept.
- **`keysched` input stability.** `ks_last_key_o` and `ks_round_o` are registers and are held constant from START until the `ks_ready_i` that ends the round. `keysched` reads them in every one of its states, so this is mandatory.
- **`ks_ready_i` outside WAIT** is ignored. This covers a stale pulse after reset or after an abort.
- **Read port**
  - `rk_o` returns entry `rk_addr_i` one cycle after the address is applied.
  - Addresses 11–15 return 0.
  - Reads are allowed in any state; entries not yet written return their old contents.
- **Read/write collision.** A read and a write to the same entry in the same cycle return the old value.
- **`busy_o`** is 1 in START and WAIT.
- **Reset mid-expansion.** Return to IDLE and clear the table. The top level resets `keysched` from the same source, inverted to its active-low input.

## Timing
- **Per-round timing.** `keysched` samples start in its state 0, then walks states 1–4, and registers ready one cycle later. `ks_ready_i` therefore arrives 5 cycles after the `ks_start_o` cycle. One round takes 6 cycles: 1 START plus 5 WAIT.
- **Full expansion, with the load accepted at cycle 0:**
  - Round-1 start at cycle 1.
  - Round-1 ready at cycle 6.
  - Round-10 ready at cycle 60.
  - `done_o` rises at cycle 61.
  - `busy_o` is high for cycles 1–60.
- **No overlap.** START is never issued in the same cycle as the `ks_ready_i` it follows.
- **Round counter** is 4 bits and ranges 1–10. It never wraps.
- **Timeout accounting.** The wait counter is 4 bits. With the default `TIMEOUT` = 8, `err_o` rises 9 cycles after a `ks_start_o` that gets no response.

## Structure
- **Package `aes_pkg`:**
  - `AES_ROUNDS` = 10.
  - `AES_KEY_W` = 128.
  - State enum `kx_state_t` with values IDLE, START, WAIT.
- **Sub-module `rk_regfile`:** 11×128 storage, one write port, one registered read port, clears on synchronous reset. The FSM stays in `key_expand_ctrl`.

## Test plan
- **Full expansion.** Bench instantiates `keysched` in the loop. Load `key_i`=2b7e151628aed2a6abf7158809cf4f3c.
  - `done_o` rises at cycle 61.
  - Entry 1 = a0fafe1788542cb123a339392a6c7605.
  - Entry 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Entry 0 = the cipher key.
  - Exactly 10 `ks_start_o` pulses, with `ks_round_o` stepping 1..10.
- **Load while busy.** Assert `load_i` with a different key at cycle 20 → ignored; the table and cycle count match the previous test.
- **Timeout.** A stub never asserts `ks_ready_i` → `err_o`=1 and `done_o`=0 at cycle 10. A following `load_i` clears `err_o`.
- **Reset mid-expansion.** Assert `reset` at cycle 30, then release → all outputs 0 and entry 5 reads 0. A new load completes normally in 61 cycles.
- **Read port.** After a completed expansion, sweep `rk_addr_i` 0..15 → registered 1-cycle latency, entries 0–10 correct, 11–15 read 0.
- **Stale ready.** Pulse `ks_ready_i` while IDLE → no table write and no state change.

Source files
------------

// File: rtl/aes_pkg.sv
// aes_pkg: shared constants and types for the AES key-expansion slice.
//   AES_ROUNDS  - number of expansion rounds (round keys 1..10)
//   AES_KEY_W   - round-key width
//   RK_ENTRIES  - round-key table depth (round 0 = cipher key)
//   LAST_ROUND  - 4-bit index of the final round / last table entry
//   kx_state_t  - expansion sequencer states
package aes_pkg;
  localparam int AES_ROUNDS = 10;
  localparam int AES_KEY_W  = 128;
  localparam int RK_ENTRIES = AES_ROUNDS + 1;
  localparam logic [3:0] LAST_ROUND = 4'(AES_ROUNDS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } kx_state_t;
endpackage

// File: rtl/rk_regfile.sv
// rk_regfile: 11 x 128 round-key table.
//   clk, reset  - clock, synchronous active-high clear of all entries
//   we/waddr/wdata - single write port
//   raddr/rdata    - registered read port; indices past the table read 0
// A same-cycle read and write of one entry returns the old contents.
module rk_regfile
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [3:0]           waddr,
  input  logic [AES_KEY_W-1:0] wdata,
  input  logic [3:0]           raddr,
  output logic [AES_KEY_W-1:0] rdata
);

  logic [AES_KEY_W-1:0] mem [RK_ENTRIES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RK_ENTRIES; i++) mem[i] <= '0;
      rdata <= '0;
    end else begin
      if (we && (waddr <= LAST_ROUND)) mem[waddr] <= wdata;
      // nonblocking read sees the pre-write value on a collision
      rdata <= (raddr <= LAST_ROUND) ? mem[raddr] : '0;
    end
  end

endmodule

// File: rtl/key_expand_ctrl.sv
// key_expand_ctrl: sequences the external keysched block through AES
// rounds 1..10 and keeps all 11 round keys in a readable table.
//   clk, reset      - clock, synchronous active-high reset
//   load_i, key_i   - start an expansion of key_i (accepted only in IDLE)
//   busy_o          - expansion in progress (START/WAIT)
//   done_o          - table holds a complete expansion
//   err_o           - last expansion aborted on timeout (sticky to next load)
//   rk_addr_i, rk_o - round-key read, one-cycle latency, 11..15 read 0
//   ks_start_o, ks_round_o, ks_last_key_o - keysched request
//   ks_new_key_i, ks_ready_i             - keysched response
module key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic [AES_KEY_W-1:0] key_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  input  logic [3:0]           rk_addr_i,
  output logic [AES_KEY_W-1:0] rk_o,
  output logic                 ks_start_o,
  output logic [3:0]           ks_round_o,
  output logic [AES_KEY_W-1:0] ks_last_key_o,
  input  logic [AES_KEY_W-1:0] ks_new_key_i,
  input  logic                 ks_ready_i
);

  localparam logic [4:0] TO = 5'(TIMEOUT);

  kx_state_t            state;
  logic [3:0]           wait_cnt;
  logic                 we;
  logic [3:0]           waddr;
  logic [AES_KEY_W-1:0] wdata;

  // Table writes: cipher key on accept, keysched result on ready in WAIT.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = ks_new_key_i;
    if (state == IDLE && load_i) begin
      we    = 1'b1;
      wdata = key_i;
    end else if (state == WAIT && ks_ready_i) begin
      we    = 1'b1;
      waddr = ks_round_o;
    end
  end

  // ks_round_o / ks_last_key_o change only on accept or on a ready, so
  // they are stable for keysched through each START..ready window.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      ks_start_o    <= 1'b0;
      ks_round_o    <= '0;
      ks_last_key_o <= '0;
    end else begin
      ks_start_o <= 1'b0;
      case (state)
        IDLE: begin
          if (load_i) begin
            ks_last_key_o <= key_i;
            ks_round_o    <= 4'd1;
            done_o        <= 1'b0;
            err_o         <= 1'b0;
            busy_o        <= 1'b1;
            ks_start_o    <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (ks_ready_i) begin
            ks_last_key_o <= ks_new_key_i;
            if (ks_round_o == LAST_ROUND) begin
              busy_o <= 1'b0;
              done_o <= 1'b1;
              state  <= IDLE;
            end else begin
              ks_round_o <= ks_round_o + 4'd1;
              ks_start_o <= 1'b1;
              state      <= START;
            end
          end else if (({1'b0, wait_cnt} + 5'd1) >= TO) begin
            // abort on the TIMEOUT-th WAIT cycle without a response
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  rk_regfile u_rk_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (rk_addr_i),
    .rdata (rk_o)
  );

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb_key_expand_ctrl: drives key_expand_ctrl with a behavioural keysched
// (AES round function built from a GF(2^8) S-box) and checks status,
// handshake timing and the round-key table against an AES key-schedule model.
module tb_key_expand_ctrl;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_i = 1'b0;
  logic [127:0] key_i = '0;
  logic         busy_o, done_o, err_o;
  logic [3:0]   rk_addr_i = '0;
  logic [127:0] rk_o;
  logic         ks_start_o;
  logic [3:0]   ks_round_o;
  logic [127:0] ks_last_key_o;
  logic [127:0] ks_new_key_i;
  logic         ks_ready_i;

  // keysched emulation and stale-pulse injection
  logic         rdy_m = 1'b0;
  logic [127:0] key_m = '0;
  logic         stale = 1'b0;
  logic [127:0] stale_key = '0;
  logic         stub = 1'b0;
  assign ks_ready_i   = rdy_m | stale;
  assign ks_new_key_i = stale ? stale_key : key_m;

  key_expand_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .load_i(load_i), .key_i(key_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .rk_addr_i(rk_addr_i), .rk_o(rk_o),
    .ks_start_o(ks_start_o), .ks_round_o(ks_round_o),
    .ks_last_key_o(ks_last_key_o), .ks_new_key_i(ks_new_key_i),
    .ks_ready_i(ks_ready_i)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  int cyc = 0;
  int t0 = 0;
  int mode = 0;          // 0 none, 1 full expansion expected, 2 timeout expected
  int n_starts = 0;
  int first_done = -1, first_err = -1;
  int pend = 0;
  int c;
  logic [3:0]   rec_round;
  logic [127:0] rec_key;
  logic [127:0] exp_tab [11];
  logic [7:0]   st_act, st_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // ---------------- AES arithmetic model ----------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] x);
    return {x[6:0], x[7]};
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv = 8'h00;
    logic [7:0] s;
    if (a != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, a);   // a^254 = a^-1
    end
    s = inv ^ rotl1(inv) ^ rotl1(rotl1(inv)) ^ rotl1(rotl1(rotl1(inv)))
        ^ rotl1(rotl1(rotl1(rotl1(inv)))) ^ 8'h63;
    return s;
  endfunction

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] x = 8'h01;
    for (int i = 1; i < r; i++) x = xtime(x);
    return x;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] prev, input int r);
    logic [31:0] w0, w1, w2, w3, rw, t;
    w0 = prev[127:96]; w1 = prev[95:64]; w2 = prev[63:32]; w3 = prev[31:0];
    rw = {w3[23:0], w3[31:24]};
    t  = {sbox(rw[31:24]), sbox(rw[23:16]), sbox(rw[15:8]), sbox(rw[7:0])}
         ^ {rcon(r), 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic void expand(input logic [127:0] k);
    exp_tab[0] = k;
    for (int r = 1; r <= 10; r++) exp_tab[r] = round_key(exp_tab[r-1], r);
  endfunction

  // ---------------- keysched emulation ----------------
  // ready is presented so that it is sampled 5 edges after the start edge.
  always @(negedge clk) begin
    if (reset) begin
      pend  = 0;
      rdy_m = 1'b0;
    end else begin
      rdy_m = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          chk("ks_round_stable", {124'h0, ks_round_o}, {124'h0, rec_round});
          chk("ks_key_stable", ks_last_key_o, rec_key);
          key_m = round_key(ks_last_key_o, int'(ks_round_o));
          rdy_m = 1'b1;
        end
      end
      if (ks_start_o) begin
        n_starts++;
        chk("start_round", {124'h0, ks_round_o}, 128'(n_starts));
        rec_round = ks_round_o;
        rec_key   = ks_last_key_o;
        if (!stub) pend = 5;
      end
    end
  end

  // ---------------- cycle-by-cycle status compare ----------------
  // cycle 1 is the first cycle after the accepting edge.
  always @(negedge clk) begin
    if (mode != 0 && !reset) begin
      c = cyc - t0 + 1;
      if (c >= 1 && c <= 75) begin
        if (mode == 1)
          st_exp = {(c <= 60), (c >= 61), 1'b0, (c <= 60 && ((c - 1) % 6) == 0),
                    (c <= 60) ? 4'((c - 1) / 6 + 1) : 4'd10};
        else
          st_exp = {(c <= 9), 1'b0, (c >= 10), (c == 1), 4'd1};
        st_act = {busy_o, done_o, err_o, ks_start_o, ks_round_o};
        chk("status", {120'h0, st_act}, {120'h0, st_exp});
        if (done_o && first_done < 0) first_done = c;
        if (err_o && first_err < 0) first_err = c;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic [127:0] k, input int m);
    @(negedge clk);
    key_i = k; load_i = 1'b1;
    n_starts = 0; first_done = -1; first_err = -1;
    @(posedge clk); #1;
    t0 = cyc; mode = m; load_i = 1'b0;
  endtask

  // 1-cycle latency: after the address moves, rk_o must still show the old read.
  task automatic sweep();
    logic [127:0] prev_exp = '0;
    for (int a = 0; a < 16; a++) begin
      @(negedge clk);
      if (a > 0) chk("rk_read", rk_o, prev_exp);
      rk_addr_i = 4'(a);
      #1;
      if (a > 0) chk("rk_latency", rk_o, prev_exp);
      prev_exp = (a <= 10) ? exp_tab[a] : '0;
    end
    @(negedge clk);
    chk("rk_read", rk_o, prev_exp);
  endtask

  task automatic read_at(input logic [3:0] a, output logic [127:0] v);
    @(negedge clk); rk_addr_i = a;
    @(negedge clk); v = rk_o;
  endtask

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] K3 = 128'hffeeddccbbaa99887766554433221100;

  logic [127:0] v;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_status", {124'h0, busy_o, done_o, err_o, ks_start_o}, 128'h0);
    chk("reset_round", {124'h0, ks_round_o}, 128'h0);
    chk("reset_lastkey", ks_last_key_o, 128'h0);
    read_at(4'd0, v);
    chk("reset_entry0", v, 128'h0);

    // stale ready straight after reset: entry 0 must stay clear
    @(negedge clk); stale_key = 128'hdeadbeef_cafef00d_01234567_89abcdef; stale = 1'b1;
    @(negedge clk); stale = 1'b0;
    @(negedge clk);
    chk("stale_rst_busy", {127'h0, busy_o}, 128'h0);
    read_at(4'd0, v);
    chk("stale_rst_entry0", v, 128'h0);

    // full expansion
    expand(K1);
    chk("model_entry1", exp_tab[1], 128'ha0fafe1788542cb123a339392a6c7605);
    chk("model_entry10", exp_tab[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    do_load(K1, 1);
    repeat (70) @(negedge clk);
    mode = 0;
    chk("done_cycle", 128'(first_done), 128'd61);
    chk("start_count", 128'(n_starts), 128'd10);
    chk("final_lastkey", ks_last_key_o, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    sweep();

    // load while busy is ignored
    do_load(K1, 1);
    repeat (20) @(negedge clk);
    key_i = K2; load_i = 1'b1;
    @(negedge clk); load_i = 1'b0;
    repeat (55) @(negedge clk);
    mode = 0;
    chk("busy_load_done_cycle", 128'(first_done), 128'd61);
    chk("busy_load_starts", 128'(n_starts), 128'd10);
    read_at(4'd0, v);  chk("busy_load_entry0", v, K1);
    read_at(4'd10, v); chk("busy_load_entry10", v, exp_tab[10]);

    // stale ready in IDLE after completion (round register still 10)
    @(negedge clk); stale = 1'b1;
    @(negedge clk); stale = 1'b0;
    @(negedge clk);
    chk("stale_status", {125'h0, busy_o, done_o, err_o}, {125'h0, 3'b010});
    chk("stale_lastkey", ks_last_key_o, exp_tab[10]);
    read_at(4'd10, v); chk("stale_entry10", v, exp_tab[10]);

    // timeout: keysched never answers
    stub = 1'b1;
    do_load(K2, 2);
    repeat (12) @(negedge clk);
    mode = 0;
    chk("err_cycle", 128'(first_err), 128'd10);
    chk("timeout_done", {127'h0, done_o}, 128'h0);
    read_at(4'd0, v); chk("timeout_entry0", v, K2);
    stub = 1'b0;
    expand(K3);
    do_load(K3, 1);
    @(negedge clk);
    chk("err_cleared", {127'h0, err_o}, 128'h0);
    repeat (69) @(negedge clk);
    mode = 0;
    chk("after_err_done_cycle", 128'(first_done), 128'd61);

    // reset mid-expansion
    expand(K2);
    do_load(K2, 1);
    repeat (30) @(negedge clk);
    mode = 0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_status", {124'h0, busy_o, done_o, err_o, ks_start_o}, 128'h0);
    chk("midrst_round", {124'h0, ks_round_o}, 128'h0);
    chk("midrst_lastkey", ks_last_key_o, 128'h0);
    chk("midrst_rk", rk_o, 128'h0);
    read_at(4'd5, v); chk("midrst_entry5", v, 128'h0);
    do_load(K2, 1);
    repeat (70) @(negedge clk);
    mode = 0;
    chk("midrst_done_cycle", 128'(first_done), 128'd61);
    sweep();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
